countdown_timer_core: RTL and testbench

- Upstream stage of the 4-digit seven-segment display path: holds an mm:ss countdown value, lets the user set it digit by digit, then counts down once per second.
- Drives the multiplexing selector with four BCD digits plus a one-hot mask of the digit under edit, which the display blinks.
- Button inputs come from the board debouncer as clean levels; this block synchronises them and edge-detects them.
- Counting uses an internal enable tick, not a derived clock.

---
 rtl/countdown_timer_pkg.sv | 21 ++
 rtl/countdown_timer_core_btn_edge.sv | 26 ++
 rtl/countdown_timer_core.sv | 137 +++++++++++++
 tb/tb_countdown_timer_core.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the mm:ss countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_SET,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  localparam logic [3:0] TENS_MAX  = 4'd5;
  localparam logic [3:0] UNITS_MAX = 4'd9;

  localparam int unsigned TICK_MAX_DEFAULT = 50_000_000;

  // Increment one BCD digit with wrap at its own limit; no carry out.
  function automatic logic [3:0] digit_inc(input logic [3:0] d, input logic [3:0] lim);
    return (d >= lim) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/countdown_timer_core_btn_edge.sv
// Two-flop synchroniser plus rising-edge detector for one debounced button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pulse
);

  logic s1_q, s2_q, prev_q;

  // Reset to 1 so a button held through reset never yields an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= btn_in;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign pulse = s2_q & ~prev_q;

endmodule

// File: rtl/countdown_timer_core.sv
// mm:ss countdown core: digit-by-digit setting, per-tick countdown, pause and done states.
module countdown_timer_core
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICK_MAX = TICK_MAX_DEFAULT,
  parameter int unsigned TICK_W   = 26
) (
  input  logic       fast_clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_inc,
  output logic [3:0] data_out_dig1,
  output logic [3:0] data_out_dig2,
  output logic [3:0] data_out_dig3,
  output logic [3:0] data_out_dig4,
  output logic [3:0] digit_to_update,
  output logic       done
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_MAX - 1);

  logic mode_e, next_e, inc_e;

  btn_edge u_mode (.clk(fast_clk), .rst(rst), .btn_in(btn_mode), .pulse(mode_e));
  btn_edge u_next (.clk(fast_clk), .rst(rst), .btn_in(btn_next), .pulse(next_e));
  btn_edge u_inc  (.clk(fast_clk), .rst(rst), .btn_in(btn_inc),  .pulse(inc_e));

  state_e            state_q, state_d;
  logic [1:0]        cursor_q, cursor_d;
  logic [3:0][3:0]   dig_q, dig_d, dec;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [3:0]        dtu_q, dtu_d;
  logic              done_q, done_d;
  logic              val_zero, dec_zero;

  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_SET;
      cursor_q <= '0;
      dig_q    <= '0;
      tick_q   <= '0;
      dtu_q    <= 4'b0001;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      dig_q    <= dig_d;
      tick_q   <= tick_d;
      dtu_q    <= dtu_d;
      done_q   <= done_d;
    end
  end

  // One-second decrement with borrow; index 0 is minutes tens.
  always_comb begin
    dec = dig_q;
    if (dig_q[3] != 4'd0) begin
      dec[3] = dig_q[3] - 4'd1;
    end else begin
      dec[3] = UNITS_MAX;
      if (dig_q[2] != 4'd0) begin
        dec[2] = dig_q[2] - 4'd1;
      end else begin
        dec[2] = TENS_MAX;
        if (dig_q[1] != 4'd0) begin
          dec[1] = dig_q[1] - 4'd1;
        end else begin
          dec[1] = UNITS_MAX;
          dec[0] = dig_q[0] - 4'd1;
        end
      end
    end
    val_zero = (dig_q == '0);
    dec_zero = (dec == '0);
  end

  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    dig_d    = dig_q;
    tick_d   = tick_q;
    case (state_q)
      ST_SET: begin
        if (mode_e) begin
          if (!val_zero) begin
            state_d = ST_RUN;
            tick_d  = '0;
          end
        end else if (next_e) begin
          cursor_d = cursor_q + 2'd1;
        end else if (inc_e) begin
          dig_d[cursor_q] = digit_inc(dig_q[cursor_q], cursor_q[0] ? UNITS_MAX : TENS_MAX);
        end
      end
      ST_RUN: begin
        // The final tick wins over a same-cycle pause request.
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          dig_d  = dec;
          if (dec_zero)    state_d = ST_DONE;
          else if (mode_e) state_d = ST_PAUSE;
        end else if (mode_e) begin
          state_d = ST_PAUSE;
        end else begin
          tick_d = tick_q + TICK_W'(1);
        end
      end
      ST_PAUSE: begin
        if (mode_e) begin
          state_d = ST_RUN;
        end else if (next_e) begin
          state_d  = ST_SET;
          cursor_d = '0;
        end
      end
      ST_DONE: begin
        dig_d = '0;
        if (mode_e || next_e) begin
          state_d  = ST_SET;
          cursor_d = '0;
        end
      end
      default: state_d = ST_SET;
    endcase
    dtu_d  = (state_d == ST_SET) ? (4'b0001 << cursor_d) : 4'b0000;
    done_d = (state_d == ST_DONE);
  end

  assign data_out_dig1   = dig_q[0];
  assign data_out_dig2   = dig_q[1];
  assign data_out_dig3   = dig_q[2];
  assign data_out_dig4   = dig_q[3];
  assign digit_to_update = dtu_q;
  assign done            = done_q;

endmodule

// File: tb/tb_countdown_timer_core.sv
// Directed bench for countdown_timer_core; a monitor checks queued expectations by cycle number.
module tb_countdown_timer_core;

  localparam logic [2:0] B_MODE = 3'b100;
  localparam logic [2:0] B_NEXT = 3'b010;
  localparam logic [2:0] B_INC  = 3'b001;

  logic       fast_clk, rst, btn_mode, btn_next, btn_inc;
  logic [3:0] dig1, dig2, dig3, dig4, dtu;
  logic       done;

  countdown_timer_core #(.TICK_MAX(4), .TICK_W(3)) dut (
    .fast_clk        (fast_clk),
    .rst             (rst),
    .btn_mode        (btn_mode),
    .btn_next        (btn_next),
    .btn_inc         (btn_inc),
    .data_out_dig1   (dig1),
    .data_out_dig2   (dig2),
    .data_out_dig3   (dig3),
    .data_out_dig4   (dig4),
    .digit_to_update (dtu),
    .done            (done)
  );

  typedef struct {
    int unsigned at;
    string       name;
    logic [15:0] digs;
    logic [3:0]  dtu;
    logic        dn;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  always @(posedge fast_clk) cyc <= cyc + 1;

  always @(negedge fast_clk) begin
    while (sb.size() > 0 && sb[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", sb[0].name, sb[0].at, cyc);
      void'(sb.pop_front());
    end
    while (sb.size() > 0 && sb[0].at == cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if ({dig1, dig2, dig3, dig4, dtu, done} !== {e.digs, e.dtu, e.dn}) begin
        errors++;
        $display("FAIL %s @%0d: got digits=%h dtu=%b done=%b, expected digits=%h dtu=%b done=%b",
                 e.name, cyc, {dig1, dig2, dig3, dig4}, dtu, done, e.digs, e.dtu, e.dn);
      end
    end
  end

  task automatic push_exp(input string nm, input int unsigned at, input logic [15:0] digs,
                          input logic [3:0] d, input logic dn);
    exp_t e;
    e.at = at; e.name = nm; e.digs = digs; e.dtu = d; e.dn = dn;
    sb.push_back(e);
  endtask

  // Called at a negedge; the action lands on the third following posedge.
  task automatic press(input logic [2:0] b, input string nm, input logic [15:0] digs,
                       input logic [3:0] d, input logic dn);
    push_exp(nm, cyc + 3, digs, d, dn);
    {btn_mode, btn_next, btn_inc} = b;
    @(posedge fast_clk);
    @(negedge fast_clk);
    {btn_mode, btn_next, btn_inc} = 3'b000;
    @(posedge fast_clk);
    @(posedge fast_clk);
    @(negedge fast_clk);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(negedge fast_clk);
  endtask

  task automatic wait_to(input int unsigned c);
    while (cyc < c) @(negedge fast_clk);
  endtask

  // Reset raised between edges and checked before any further posedge.
  task automatic rst_pulse(input string nm);
    @(posedge fast_clk);
    #2 rst = 1'b1;
    push_exp(nm, cyc, 16'h0000, 4'b0001, 1'b0);
    #1;
    checks++;
    if ({dig1, dig2, dig3, dig4} !== 16'h0000 || dtu !== 4'b0001 || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_async: got digits=%h dtu=%b done=%b", nm, {dig1, dig2, dig3, dig4}, dtu, done);
    end
    @(negedge fast_clk);
    @(posedge fast_clk);
    @(negedge fast_clk);
    rst = 1'b0;
    @(negedge fast_clk);
  endtask

  logic [3:0]  d1_seq [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
  int unsigned t, r;

  initial begin
    rst = 1'b0; btn_mode = 1'b0; btn_next = 1'b0; btn_inc = 1'b1;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({dig1, dig2, dig3, dig4} !== 16'h0000 || dtu !== 4'b0001 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_immediate: got digits=%h dtu=%b done=%b", {dig1, dig2, dig3, dig4}, dtu, done);
    end
    idle(2);
    push_exp("reset_state", cyc + 1, 16'h0000, 4'b0001, 1'b0);
    @(negedge fast_clk);
    rst = 1'b0;
    push_exp("inc_held_through_reset", cyc + 5, 16'h0000, 4'b0001, 1'b0);
    idle(5);
    btn_inc = 1'b0;
    idle(3);

    // Digit editing and wrap limits
    press(B_NEXT, "cursor_to_dig2", 16'h0000, 4'b0010, 1'b0);
    for (int i = 1; i <= 7; i++)
      press(B_INC, "inc_dig2", {4'd0, 4'(i), 8'h00}, 4'b0010, 1'b0);
    press(B_NEXT, "cursor_to_dig3", 16'h0700, 4'b0100, 1'b0);
    press(B_NEXT, "cursor_to_dig4", 16'h0700, 4'b1000, 1'b0);
    press(B_NEXT, "cursor_wrap_dig1", 16'h0700, 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++)
      press(B_INC, "inc_dig1_wrap5", {d1_seq[i], 4'd7, 8'h00}, 4'b0001, 1'b0);
    press(B_NEXT, "cursor_dig2_again", 16'h0700, 4'b0010, 1'b0);
    press(B_INC, "dig2_8", 16'h0800, 4'b0010, 1'b0);
    press(B_INC, "dig2_9", 16'h0900, 4'b0010, 1'b0);
    press(B_INC, "dig2_wrap9", 16'h0000, 4'b0010, 1'b0);
    press(B_MODE, "mode_zero_stays_set", 16'h0000, 4'b0010, 1'b0);
    press(B_INC, "set_0100", 16'h0100, 4'b0010, 1'b0);
    press(B_MODE, "run_0100", 16'h0100, 4'b0000, 1'b0);
    t = cyc;
    push_exp("run_before_tick", t + 3, 16'h0100, 4'b0000, 1'b0);
    push_exp("borrow_0100_0059", t + 4, 16'h0059, 4'b0000, 1'b0);
    wait_to(t + 6);
    rst_pulse("rst_mid_run");

    // Borrow through every digit
    press(B_INC, "set_1000", 16'h1000, 4'b0001, 1'b0);
    press(B_MODE, "run_1000", 16'h1000, 4'b0000, 1'b0);
    t = cyc;
    push_exp("borrow_1000_0959", t + 4, 16'h0959, 4'b0000, 1'b0);
    wait_to(t + 5);
    rst_pulse("rst_after_borrow");

    // Count to zero, DONE, acknowledge
    press(B_NEXT, "c_dig2", 16'h0000, 4'b0010, 1'b0);
    press(B_NEXT, "c_dig3", 16'h0000, 4'b0100, 1'b0);
    press(B_NEXT, "c_dig4", 16'h0000, 4'b1000, 1'b0);
    press(B_INC, "set_0001", 16'h0001, 4'b1000, 1'b0);
    press(B_INC, "set_0002", 16'h0002, 4'b1000, 1'b0);
    press(B_MODE, "run_0002", 16'h0002, 4'b0000, 1'b0);
    t = cyc;
    push_exp("count_0001", t + 4, 16'h0001, 4'b0000, 1'b0);
    push_exp("hold_0001", t + 7, 16'h0001, 4'b0000, 1'b0);
    push_exp("done_at_zero", t + 8, 16'h0000, 4'b0000, 1'b1);
    wait_to(t + 8);
    press(B_INC, "done_ignores_inc", 16'h0000, 4'b0000, 1'b1);
    press(B_MODE, "done_mode_to_set", 16'h0000, 4'b0001, 1'b0);

    // Pause keeps value and tick phase
    press(B_NEXT, "p_dig2", 16'h0000, 4'b0010, 1'b0);
    press(B_NEXT, "p_dig3", 16'h0000, 4'b0100, 1'b0);
    press(B_NEXT, "p_dig4", 16'h0000, 4'b1000, 1'b0);
    for (int i = 1; i <= 5; i++)
      press(B_INC, "p_inc_dig4", {12'h000, 4'(i)}, 4'b1000, 1'b0);
    press(B_MODE, "run_0005", 16'h0005, 4'b0000, 1'b0);
    t = cyc;
    press(B_MODE, "pause_at_tick2", 16'h0005, 4'b0000, 1'b0);
    push_exp("pause_holds_20", t + 23, 16'h0005, 4'b0000, 1'b0);
    wait_to(t + 23);
    press(B_MODE, "resume", 16'h0005, 4'b0000, 1'b0);
    r = cyc;
    push_exp("resume_no_dec_yet", r + 1, 16'h0005, 4'b0000, 1'b0);
    push_exp("resume_dec_after_2", r + 2, 16'h0004, 4'b0000, 1'b0);
    wait_to(r + 2);
    press(B_MODE, "pause_again", 16'h0004, 4'b0000, 1'b0);
    press(B_NEXT, "pause_next_to_set", 16'h0004, 4'b0001, 1'b0);

    // All three buttons together in SET
    rst_pulse("rst_before_combo");
    press(B_NEXT, "k_dig2", 16'h0000, 4'b0010, 1'b0);
    press(B_NEXT, "k_dig3", 16'h0000, 4'b0100, 1'b0);
    press(B_NEXT, "k_dig4", 16'h0000, 4'b1000, 1'b0);
    for (int i = 1; i <= 3; i++)
      press(B_INC, "k_inc_dig4", {12'h000, 4'(i)}, 4'b1000, 1'b0);
    press(B_MODE | B_NEXT | B_INC, "combo_runs_only", 16'h0003, 4'b0000, 1'b0);
    t = cyc;
    press(B_INC, "run_ignores_inc", 16'h0003, 4'b0000, 1'b0);
    push_exp("combo_then_count", t + 4, 16'h0002, 4'b0000, 1'b0);
    wait_to(t + 4);

    // Mode on the final tick goes to DONE
    rst_pulse("rst_before_final");
    press(B_NEXT, "f_dig2", 16'h0000, 4'b0010, 1'b0);
    press(B_NEXT, "f_dig3", 16'h0000, 4'b0100, 1'b0);
    press(B_NEXT, "f_dig4", 16'h0000, 4'b1000, 1'b0);
    press(B_INC, "f_set_0001", 16'h0001, 4'b1000, 1'b0);
    press(B_MODE, "run_0001", 16'h0001, 4'b0000, 1'b0);
    idle(1);
    press(B_MODE, "final_tick_beats_pause", 16'h0000, 4'b0000, 1'b1);
    press(B_NEXT, "done_next_to_set", 16'h0000, 4'b0001, 1'b0);

    idle(5);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard not drained: %0d expectations left", sb.size());
    end
    if (checks < 12) begin
      errors++;
      $display("FAIL too few checks executed: %0d", checks);
    end
    if (errors == 0) $display("PASS");
    else             $display("FAIL");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
